pong_round_ctrl: RTL and testbench
==================================

# pong_round_ctrl

Round/serve sequencer for the Pong datapath. Sequences the ball motion logic and score counters: holds the ball centred for a fixed number of frames before each serve, releases it for play, turns paddle misses into score increments, picks the next serve direction and declares a winner. Sits between the frame-tick generator, the ball/paddle collision logic and the score display.

## Interface
- SERVE_FRAMES, 60: frame ticks the ball stays centred before release (≥1).
- WIN_SCORE, 7: score that ends the game (≥1, < 2^SW).
- SW, 4: score counter width.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  one-cycle pulse, debounced upstream.
- miss_left  in  1  one-cycle pulse: ball passed left paddle.
- miss_right  in  1  one-cycle pulse: ball passed right paddle.
- ball_en  out  1  ball motion enable.
- ball_center  out  1  hold ball at screen centre.
- serve_dir  out  1  0 = serve toward left, 1 = toward right.
- score_left, score_right  out  SW  current scores.
- point  out  1  one-cycle pulse when a point is awarded.
- game_over  out  1  high while game is finished.
- winner  out  1  0 = left, 1 = right; valid while game_over.
- state  out  3  current FSM state (debug/display).

## Operation
- States: IDLE, SERVE, PLAY, POINT, OVER.
- IDLE: ball_center=1, ball_en=0. start → SERVE, scores cleared, serve counter cleared.
- SERVE: ball_center=1, ball_en=0. Serve counter increments on frame_tick; on frame_tick with counter == SERVE_FRAMES-1 → PLAY, counter cleared. Misses and start ignored.
- PLAY: ball_en=1, ball_center=0. miss_left only → score_right+1, serve_dir=0. miss_right only → score_left+1, serve_dir=1. If incremented score == WIN_SCORE → OVER (winner = scorer), else → POINT. miss_left and miss_right same cycle → no score change, serve_dir unchanged, → SERVE (replay). start ignored.
- POINT: exactly one cycle; point=1, ball_center=1, ball_en=0; → SERVE.
- OVER: game_over=1, ball_center=1, ball_en=0; scores and winner frozen. start → SERVE, scores cleared, winner/game_over cleared, serve_dir = loser's side.
- Scores never wrap; saturation is implied by the transition to OVER.
- frame_tick coinciding with a miss in PLAY: the miss wins; tick has no effect.

## Timing
- All outputs registered; each responds on the clock edge after the qualifying input is sampled.
- Reset values: state=IDLE, ball_en=0, ball_center=1, serve_dir=0, scores=0, point=0, game_over=0, winner=0, serve counter=0.
- Reset mid-game: immediate return to reset values; no pending point survives.
- Serve latency: PLAY entered on the edge sampling the SERVE_FRAMES-th frame_tick after entering SERVE; SERVE_FRAMES=1 → first tick.
- Score and state update on the same edge; point asserts in the following cycle (POINT state).
- Serve counter width $clog2(SERVE_FRAMES), minimum 1.

## Structure
- Shared package pong_pkg: state encoding constants (IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4), side constants LEFT=0/RIGHT=1.
- One natural sub-module: score_counter (SW-bit, async reset, synchronous clear, increment enable), instantiated once per player.
- FSM, serve counter and direction/winner registers in the top module.

## Test plan
(SERVE_FRAMES=4, WIN_SCORE=3)
- Reset asserted mid-PLAY with score_left=2 → next cycle state=IDLE, scores 0, ball_center=1, ball_en=0.
- start, then 4 frame_ticks → ball_en rises on edge after the 4th tick; 3 ticks → still SERVE.
- PLAY, miss_right pulse → score_left=1, serve_dir=1, point pulses one cycle, back to SERVE, ball_center=1.
- PLAY, miss_left and miss_right same cycle → scores unchanged, no point pulse, state=SERVE.
- Right reaches 3 via three miss_left → game_over=1, winner=1, scores frozen at 0/3; misses ignored; start → scores 0, serve_dir=0, state=SERVE.
- start during SERVE/PLAY and frame_tick colliding with miss in PLAY → start ignored; miss scored exactly once.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the Pong round sequencer: FSM state encoding and
// side constants used for serve direction and winner.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  // The next game is served toward the side that lost the previous one.
  function automatic logic loser_side(input logic winner_side);
    return ~winner_side;
  endfunction

endpackage

// File: rtl/score_counter.sv
// Per-player score register: synchronous clear has priority over increment.
module score_counter #(
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [SW-1:0] score
);

  logic [SW-1:0] score_r;

  // Score register with async reset, sync clear and increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_r <= {SW{1'b0}};
    end else if (clr) begin
      score_r <= {SW{1'b0}};
    end else if (inc) begin
      score_r <= score_r + SW'(1);
    end else begin
      score_r <= score_r;
    end
  end

  assign score = score_r;

endmodule

// File: rtl/pong_round_ctrl.sv
// Round/serve sequencer: centres the ball before each serve, releases it for
// play, converts paddle misses into points and declares the game winner.
module pong_round_ctrl
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7,
  parameter int SW           = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_tick,
  input  logic          start,
  input  logic          miss_left,
  input  logic          miss_right,
  output logic          ball_en,
  output logic          ball_center,
  output logic          serve_dir,
  output logic [SW-1:0] score_left,
  output logic [SW-1:0] score_right,
  output logic          point,
  output logic          game_over,
  output logic          winner,
  output logic [2:0]    state
);

  localparam int CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CW-1:0] LAST_FRAME  = CW'(SERVE_FRAMES - 1);
  localparam logic [SW-1:0] WIN_MINUS_1 = SW'(WIN_SCORE - 1);

  state_t        state_r;
  state_t        state_next_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          serve_dir_r;
  logic          dir_next_s;
  logic          winner_r;
  logic          winner_next_s;
  logic          ball_en_r;
  logic          ball_center_r;
  logic          point_r;
  logic          game_over_r;
  logic          clr_s;
  logic          inc_left_s;
  logic          inc_right_s;

  // Next-state, serve counter, direction/winner and score control decode.
  always_comb begin
    state_next_s  = state_r;
    cnt_next_s    = cnt_r;
    dir_next_s    = serve_dir_r;
    winner_next_s = winner_r;
    clr_s         = 1'b0;
    inc_left_s    = 1'b0;
    inc_right_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = SERVE;
          cnt_next_s   = {CW{1'b0}};
          clr_s        = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (cnt_r == LAST_FRAME) begin
            state_next_s = PLAY;
            cnt_next_s   = {CW{1'b0}};
          end else begin
            cnt_next_s   = cnt_r + CW'(1);
          end
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      PLAY: begin
        // Simultaneous misses are a replay; a tick coinciding with a miss is dropped.
        if (miss_left && miss_right) begin
          state_next_s = SERVE;
        end else if (miss_left) begin
          inc_right_s = 1'b1;
          dir_next_s  = LEFT;
          if (score_right == WIN_MINUS_1) begin
            state_next_s  = OVER;
            winner_next_s = RIGHT;
          end else begin
            state_next_s  = POINT;
          end
        end else if (miss_right) begin
          inc_left_s = 1'b1;
          dir_next_s = RIGHT;
          if (score_left == WIN_MINUS_1) begin
            state_next_s  = OVER;
            winner_next_s = LEFT;
          end else begin
            state_next_s  = POINT;
          end
        end else begin
          state_next_s = PLAY;
        end
      end
      POINT: begin
        state_next_s = SERVE;
      end
      OVER: begin
        if (start) begin
          state_next_s  = SERVE;
          cnt_next_s    = {CW{1'b0}};
          clr_s         = 1'b1;
          dir_next_s    = loser_side(winner_r);
          winner_next_s = LEFT;
        end else begin
          state_next_s = OVER;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = {CW{1'b0}};
      end
    endcase
  end

  // State, counter and registered output flags, derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      cnt_r         <= {CW{1'b0}};
      serve_dir_r   <= LEFT;
      winner_r      <= LEFT;
      ball_en_r     <= 1'b0;
      ball_center_r <= 1'b1;
      point_r       <= 1'b0;
      game_over_r   <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      cnt_r         <= cnt_next_s;
      serve_dir_r   <= dir_next_s;
      winner_r      <= winner_next_s;
      ball_en_r     <= (state_next_s == PLAY);
      ball_center_r <= (state_next_s != PLAY);
      point_r       <= (state_next_s == POINT);
      game_over_r   <= (state_next_s == OVER);
    end
  end

  score_counter #(.SW(SW)) u_score_left (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .inc   (inc_left_s),
    .score (score_left)
  );

  score_counter #(.SW(SW)) u_score_right (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .inc   (inc_right_s),
    .score (score_right)
  );

  assign ball_en     = ball_en_r;
  assign ball_center = ball_center_r;
  assign serve_dir   = serve_dir_r;
  assign point       = point_r;
  assign game_over   = game_over_r;
  assign winner      = winner_r;
  assign state       = state_r;

endmodule

// File: tb/tb_pong_round_ctrl.sv
// Self-checking bench for pong_round_ctrl: directed scenarios followed by
// random traffic, all compared against a rule-level game model.
module tb_pong_round_ctrl;

  localparam int SF = 4;
  localparam int WS = 3;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_tick = 1'b0;
  logic          start = 1'b0;
  logic          miss_left = 1'b0;
  logic          miss_right = 1'b0;
  logic          ball_en;
  logic          ball_center;
  logic          serve_dir;
  logic [SW-1:0] score_left;
  logic [SW-1:0] score_right;
  logic          point;
  logic          game_over;
  logic          winner;
  logic [2:0]    state;

  int n_checks = 0;
  int n_fail   = 0;

  // Game model: phase 0 idle, 1 serving, 2 in play, 3 point shown, 4 game over.
  int   m_phase  = 0;
  int   m_ticks  = 0;
  int   m_sl     = 0;
  int   m_sr     = 0;
  logic m_dir    = 1'b0;
  logic m_win    = 1'b0;

  pong_round_ctrl #(.SERVE_FRAMES(SF), .WIN_SCORE(WS), .SW(SW)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .start       (start),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .ball_en     (ball_en),
    .ball_center (ball_center),
    .serve_dir   (serve_dir),
    .score_left  (score_left),
    .score_right (score_right),
    .point       (point),
    .game_over   (game_over),
    .winner      (winner),
    .state       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("state", {29'd0, state}, m_phase);
    chk("ball_en", {31'd0, ball_en}, (m_phase == 2) ? 32'd1 : 32'd0);
    chk("ball_center", {31'd0, ball_center}, (m_phase != 2) ? 32'd1 : 32'd0);
    chk("point", {31'd0, point}, (m_phase == 3) ? 32'd1 : 32'd0);
    chk("game_over", {31'd0, game_over}, (m_phase == 4) ? 32'd1 : 32'd0);
    chk("score_left", {28'd0, score_left}, m_sl);
    chk("score_right", {28'd0, score_right}, m_sr);
    chk("serve_dir", {31'd0, serve_dir}, {31'd0, m_dir});
    chk("winner", {31'd0, winner}, {31'd0, m_win});
  endtask

  task automatic model_reset();
    m_phase = 0; m_ticks = 0; m_sl = 0; m_sr = 0; m_dir = 1'b0; m_win = 1'b0;
  endtask

  task automatic model_step(input logic ft, input logic st, input logic ml, input logic mr);
    case (m_phase)
      0: if (st) begin m_phase = 1; m_sl = 0; m_sr = 0; m_ticks = 0; end
      1: if (ft) begin
           m_ticks++;
           if (m_ticks == SF) begin m_phase = 2; m_ticks = 0; end
         end
      2: if (ml && mr) m_phase = 1;
         else if (ml) begin
           m_sr++; m_dir = 1'b0;
           if (m_sr == WS) begin m_phase = 4; m_win = 1'b1; end else m_phase = 3;
         end else if (mr) begin
           m_sl++; m_dir = 1'b1;
           if (m_sl == WS) begin m_phase = 4; m_win = 1'b0; end else m_phase = 3;
         end
      3: m_phase = 1;
      4: if (st) begin
           m_phase = 1; m_sl = 0; m_sr = 0; m_ticks = 0; m_dir = !m_win; m_win = 1'b0;
         end
      default: m_phase = 0;
    endcase
  endtask

  task automatic cycle(input logic ft, input logic st, input logic ml, input logic mr);
    @(negedge clk);
    frame_tick = ft; start = st; miss_left = ml; miss_right = mr;
    @(posedge clk);
    model_step(ft, st, ml, mr);
    #1;
    frame_tick = 1'b0; start = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    frame_tick = 1'b0; start = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic serve_to_play();
    for (int i = 0; i < 20 && m_phase != 2; i++) cycle(i % 2 == 0, 1'b0, 1'b0, 1'b0);
    chk("reach_play", {29'd0, state}, 32'd2);
  endtask

  initial begin
    do_reset();

    // Serve latency: three ticks keep the ball centred, the fourth releases it.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("serve_after_3_ticks", {29'd0, state}, 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ball_en_after_4_ticks", {31'd0, ball_en}, 32'd1);

    // Right paddle miss: left scores, serve toward right, one-cycle point.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("left_scored", {28'd0, score_left}, 32'd1);
    chk("point_pulse", {31'd0, point}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("point_cleared", {31'd0, point}, 32'd0);
    serve_to_play();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    serve_to_play();

    // Reset in the middle of play with the left player on 2.
    chk("left_on_two", {28'd0, score_left}, 32'd2);
    do_reset();

    // Double miss is a replay; start in play ignored; tick+miss scores once.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    serve_to_play();
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("replay_state", {29'd0, state}, 32'd1);
    serve_to_play();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk("collision_scored_once", {28'd0, score_right}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    serve_to_play();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    serve_to_play();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("right_wins", {31'd0, winner}, 32'd1);

    // Game over: misses and ticks ignored, then restart toward the loser.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("restart_dir_left", {31'd0, serve_dir}, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(1) == 1, $urandom_range(15) == 0,
            $urandom_range(7) == 0, $urandom_range(7) == 0);
      if ($urandom_range(199) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
